uart_frame_parser: RTL

//  Downstream consumer of the UART receive FIFO (rx_empty/r_data/rd_uart).

---
 rtl/uart_frame_parser.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops bytes from a UART RX FIFO, hunts for frames of the
// form SOF, LEN, LEN payload bytes, CHK, and streams the payload on a
// registered valid/ready byte port. Every frame ends with a one-cycle
// frame_ok or frame_err pulse so the sink can commit or discard it.
// CHK is chosen so that LEN ^ payload bytes ^ CHK == 0.
//
// Optional feature: define FRAME_TIMEOUT_EN to abort a frame when no byte
// arrives for TIMEOUT_CYC cycles. This adds the TIMEOUT_CYC and TO_W
// parameters. Without the macro the parser waits indefinitely for bytes.
//
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active low
//   rx_empty   RX FIFO empty
//   r_data     RX FIFO head byte, valid while rx_empty is low
//   rd_uart    RX FIFO pop strobe (combinational)
//   m_data     payload byte
//   m_valid    m_data valid
//   m_last     final payload byte of the frame
//   m_ready    sink accepts m_data
//   frame_ok   one-cycle pulse: checksum good
//   frame_err  one-cycle pulse: frame aborted
//   err_code   01 length too large, 10 bad checksum, 11 timeout
//   frame_cnt  count of good frames, wraps
module uart_frame_parser #(
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN     = 16
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned TO_W        = 18
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_t;

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
`ifdef FRAME_TIMEOUT_EN
    localparam logic [1:0] ERR_TO  = 2'b11;
`endif

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  chk_acc, chk_n;
    logic [7:0]  data_n;
    logic        valid_n, last_n;
    logic        ok_n, err_n;
    logic [1:0]  code_n;
    logic [15:0] fcnt_n;
`ifdef FRAME_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt, to_n;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            chk_acc   <= 8'd0;
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            frame_cnt <= 16'd0;
`ifdef FRAME_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            chk_acc   <= chk_n;
            m_data    <= data_n;
            m_valid   <= valid_n;
            m_last    <= last_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;
            err_code  <= code_n;
            frame_cnt <= fcnt_n;
`ifdef FRAME_TIMEOUT_EN
            to_cnt    <= to_n;
`endif
        end
    end

    // Pop strobe, frame hunting and next-register values
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        chk_n   = chk_acc;
        data_n  = m_data;
        // An accepted byte empties the output register unless reloaded below
        valid_n = m_valid & ~m_ready;
        last_n  = m_last & ~m_ready;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        code_n  = err_code;
        fcnt_n  = frame_cnt;

        // In PAYLOAD a pop needs room in the output register (or a drain now)
        rd_uart = ~rx_empty;
        if (state == ST_PAYLOAD) begin
            rd_uart = ~rx_empty & (~m_valid | m_ready);
        end

        case (state)
            ST_IDLE: begin
                if (rd_uart && r_data == SOF_BYTE) begin
                    state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rd_uart) begin
                    chk_n = r_data;
                    cnt_n = r_data;
                    if (r_data > 8'(MAX_LEN)) begin
                        err_n   = 1'b1;
                        code_n  = ERR_LEN;
                        state_n = ST_IDLE;
                    end else if (r_data == 8'd0) begin
                        state_n = ST_CHK;
                    end else begin
                        state_n = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_uart) begin
                    data_n  = r_data;
                    valid_n = 1'b1;
                    last_n  = (cnt == 8'd1);
                    chk_n   = chk_acc ^ r_data;
                    cnt_n   = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_n = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rd_uart) begin
                    if ((chk_acc ^ r_data) == 8'd0) begin
                        ok_n   = 1'b1;
                        fcnt_n = frame_cnt + 16'd1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = ERR_CHK;
                    end
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

`ifdef FRAME_TIMEOUT_EN
        // Idle-gap counter; a pop in the expiry cycle takes precedence
        to_n = (rd_uart || state == ST_IDLE) ? '0 : to_cnt + TO_W'(1);
        if (state != ST_IDLE && !rd_uart && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            err_n   = 1'b1;
            code_n  = ERR_TO;
            state_n = ST_IDLE;
            to_n    = '0;
        end
`endif
    end

endmodule
